// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: elastic, multi-stage RV64I/RV32I shift unit.
// Handles SLL/SRL/SRA and the RV64 word forms SLLW/SRLW/SRAW. The shift
// amount is split across PIPE_STAGES register stages so that each stage only
// implements part of the barrel shifter. A sideband tag rides with each op.
module shift_unit_pipe #(
  parameter int XLEN        = 64,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5,
  localparam int SHW        = $clog2(XLEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_y,
  output logic [TAG_W-1:0] out_tag
);

  // Word forms only exist on a 64-bit datapath; on RV32 they alias full ops.
  localparam bit HAS_WORD = (XLEN == 64);

  // Direction/fill of the shift, carried through every stage.
  typedef enum logic [1:0] {
    KIND_SLL = 2'd0,
    KIND_SRL = 2'd1,
    KIND_SRA = 2'd2
  } kind_e;

  // One in-flight operation: partially shifted value plus what the later
  // stages still need (remaining shamt bits, direction, word flag, tag).
  typedef struct packed {
    logic [XLEN-1:0]  val;
    logic [SHW-1:0]   sh;
    kind_e            kind;
    logic             word;
    logic [TAG_W-1:0] tag;
  } entry_t;

  // Applies the shamt bits owned by 'stage': bit i belongs to stage
  // floor(i*PIPE_STAGES/SHW). SRA fills with the current MSB, which equals
  // the original sign because arithmetic shifts preserve it.
  function automatic logic [XLEN-1:0] shift_stage(
    input logic [XLEN-1:0] v,
    input logic [SHW-1:0]  sh,
    input kind_e           kind,
    input int              stage
  );
    logic [XLEN-1:0] r;
    r = v;
    for (int i = 0; i < SHW; i++) begin
      if (((i * PIPE_STAGES) / SHW == stage) && sh[i]) begin
        case (kind)
          KIND_SLL: r = r << (1 << i);
          KIND_SRA: r = $unsigned($signed(r) >>> (1 << i));
          default:  r = r >> (1 << i);
        endcase
      end
    end
    return r;
  endfunction

  entry_t             pre_d;
  entry_t             stage_in [PIPE_STAGES];
  entry_t             stage_d  [PIPE_STAGES];
  entry_t             ent_q    [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] valid_q;
  logic [PIPE_STAGES-1:0] valid_in;
  logic [PIPE_STAGES-1:0] load;
  logic [XLEN-1:0]    a_zext;
  logic [XLEN-1:0]    a_sext;
  logic [SHW-1:0]     sh_word;
  logic               word_op;

  // Decode the request into a uniform entry. Word ops widen a[31:0] so the
  // low 32 result bits come out of the full-width shifter unchanged; the
  // final sign-extension happens in the last stage. Reserved ops enter with
  // a zero operand, so every shift of it yields zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    a_zext  = in_a;
    a_sext  = in_a;
    sh_word = in_shamt;
    for (int b = 32; b < XLEN; b++) begin
      a_zext[b] = 1'b0;
      a_sext[b] = in_a[31];
    end
    for (int b = 5; b < SHW; b++) begin
      sh_word[b] = 1'b0;
    end
    word_op    = HAS_WORD && in_op[2];
    pre_d      = '0;
    pre_d.tag  = in_tag;
    pre_d.kind = KIND_SRL;
    case (in_op[1:0])
      2'b00:   pre_d.kind = KIND_SLL;
      2'b10:   pre_d.kind = KIND_SRA;
      default: pre_d.kind = KIND_SRL;
    endcase
    if (in_op[1:0] != 2'b11) begin
      pre_d.word = word_op;
      pre_d.sh   = word_op ? sh_word : in_shamt;
      if (!word_op) begin
        pre_d.val = in_a;
      end else if (in_op[1:0] == 2'b10) begin
        pre_d.val = a_sext;
      end else begin
        pre_d.val = a_zext;
      end
    end
  end

  // Per-stage next values: each stage takes the previous stage's register
  // (stage 0 takes the decoded request) and applies its own shamt bits.
  always_comb begin
    stage_in[0] = pre_d;
    valid_in[0] = in_valid;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      stage_in[k] = ent_q[k-1];
      valid_in[k] = valid_q[k-1];
    end
    for (int k = 0; k < PIPE_STAGES; k++) begin
      stage_d[k]     = stage_in[k];
      stage_d[k].val = shift_stage(stage_in[k].val, stage_in[k].sh,
                                   stage_in[k].kind, k);
    end
    if (stage_d[PIPE_STAGES-1].word) begin
      for (int b = 32; b < XLEN; b++) begin
        stage_d[PIPE_STAGES-1].val[b] = stage_d[PIPE_STAGES-1].val[31];
      end
    end
  end

  // Elastic load enables: a stage loads when it, or any stage after it, is
  // empty, or when the consumer takes the last result this cycle.
  always_comb begin
    logic acc;
    acc  = out_ready;
    load = '0;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      acc     = acc || !valid_q[k];
      load[k] = acc;
    end
  end

  assign in_ready = load[0] && rst_n;

  // Stage registers: advance every stage whose load enable is set; data only
  // moves with a valid entry so the output holds its last result otherwise.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every stage samples the values its
    // neighbours held before this edge, independent of statement order.
    if (!rst_n) begin
      valid_q <= '0;
      // NOTE: the entry storage is cleared too, not just the valid bits, so
      // out_y/out_tag read as zero straight after reset.
      for (int k = 0; k < PIPE_STAGES; k++) begin
        ent_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        if (load[k]) begin
          valid_q[k] <= valid_in[k];
          if (valid_in[k]) begin
            ent_q[k] <= stage_d[k];
          end
        end
      end
    end
  end

  assign out_valid = valid_q[PIPE_STAGES-1];
  assign out_y     = ent_q[PIPE_STAGES-1].val;
  assign out_tag   = ent_q[PIPE_STAGES-1].tag;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Testbench for shift_unit_pipe: three instances (2, 1 and 6 stages) share
// the operand inputs; each test drives one instance at a time and compares
// its results with a plain-arithmetic reference model.
module tb_shift_unit_pipe;
  localparam int NI = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      in_op;
  logic [63:0]     in_a;
  logic [5:0]      in_shamt;
  logic [4:0]      in_tag;
  logic [NI-1:0]   in_valid_v, in_ready_v, out_valid_v, out_ready_v;
  logic [63:0]     out_y_v   [NI];
  logic [4:0]      out_tag_v [NI];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] y;
    logic [4:0]  tag;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [63:0] a;
    logic [5:0]  sh;
    logic [63:0] y;
  } dvec_t;
  dvec_t vq[$];

  always #5 clk = ~clk;

  shift_unit_pipe #(.XLEN(64), .PIPE_STAGES(2), .TAG_W(5)) u_ps2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_op(in_op), .in_a(in_a), .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out_y(out_y_v[0]), .out_tag(out_tag_v[0]));

  shift_unit_pipe #(.XLEN(64), .PIPE_STAGES(1), .TAG_W(5)) u_ps1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_op(in_op), .in_a(in_a), .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out_y(out_y_v[1]), .out_tag(out_tag_v[1]));

  shift_unit_pipe #(.XLEN(64), .PIPE_STAGES(6), .TAG_W(5)) u_ps6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_op(in_op), .in_a(in_a), .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .out_y(out_y_v[2]), .out_tag(out_tag_v[2]));

  function automatic int ps_of(input int s);
    return (s == 0) ? 2 : (s == 1) ? 1 : 6;
  endfunction

  // Reference: RISC-V shift semantics written directly with SV operators.
  function automatic logic [63:0] ref_shift(input logic [2:0] op,
                                            input logic [63:0] a,
                                            input logic [5:0] sh);
    logic [31:0] lo;
    logic [31:0] w;
    int          n;
    lo = a[31:0];
    n  = int'(sh[4:0]);
    w  = 32'd0;
    case (op)
      3'd0:    return a << sh;
      3'd1:    return a >> sh;
      3'd2:    return $unsigned($signed(a) >>> sh);
      3'd4:    w = lo << n;
      3'd5:    w = lo >> n;
      3'd6:    w = $unsigned($signed(lo) >>> n);
      default: return 64'd0;
    endcase
    return {{32{w[31]}}, w};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid_v  = '0;
    out_ready_v = '0;
    in_op       = 3'd0;
    in_a        = 64'd0;
    in_shamt    = 6'd0;
    in_tag      = 5'd0;
  endtask

  task automatic add_vec(input string n, input logic [2:0] op, input logic [63:0] a,
                         input logic [5:0] sh, input logic [63:0] y);
    dvec_t v;
    v.name = n; v.op = op; v.a = a; v.sh = sh; v.y = y;
    vq.push_back(v);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    out_ready_v = '1;
    repeat (3) cycle();
    for (int s = 0; s < NI; s++) begin
      checks++;
      if (in_ready_v[s] !== 1'b0) begin
        errors++; $display("FAIL reset_in_ready[%0d]: got %b expected 0", s, in_ready_v[s]);
      end
      checks++;
      if (out_valid_v[s] !== 1'b0) begin
        errors++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", s, out_valid_v[s]);
      end
      checks++;
      if (out_y_v[s] !== 64'd0) begin
        errors++; $display("FAIL reset_out_y[%0d]: got %h expected 0", s, out_y_v[s]);
      end
      checks++;
      if (out_tag_v[s] !== 5'd0) begin
        errors++; $display("FAIL reset_out_tag[%0d]: got %h expected 0", s, out_tag_v[s]);
      end
    end
    rst_n = 1'b1;
    #1;
    for (int s = 0; s < NI; s++) begin
      checks++;
      if (in_ready_v[s] !== 1'b1) begin
        errors++; $display("FAIL post_reset_in_ready[%0d]: got %b expected 1", s, in_ready_v[s]);
      end
    end
    cycle();
    idle_inputs();
  endtask

  task automatic test_directed();
    int n;
    int lat;
    vq.delete();
    add_vec("sra_4",     3'd2, 64'h0123456789ABCDEF, 6'd4,  64'h00123456789ABCDE);
    add_vec("sra_32",    3'd2, 64'hAAAAAAAAAAAAAAAA, 6'd32, 64'hFFFFFFFFAAAAAAAA);
    add_vec("sra_ones",  3'd2, 64'hFFFFFFFFFFFFFFFF, 6'd8,  64'hFFFFFFFFFFFFFFFF);
    add_vec("sll_63",    3'd0, 64'h0000000000000001, 6'd63, 64'h8000000000000000);
    add_vec("srl_63",    3'd1, 64'h8000000000000000, 6'd63, 64'h0000000000000001);
    add_vec("sll_0",     3'd0, 64'hDEADBEEFCAFEF00D, 6'd0,  64'hDEADBEEFCAFEF00D);
    add_vec("srl_0",     3'd1, 64'hDEADBEEFCAFEF00D, 6'd0,  64'hDEADBEEFCAFEF00D);
    add_vec("sra_0",     3'd2, 64'hDEADBEEFCAFEF00D, 6'd0,  64'hDEADBEEFCAFEF00D);
    add_vec("sraw_4",    3'd6, 64'h0000000080000000, 6'd4,  64'hFFFFFFFFF8000000);
    add_vec("sllw_31",   3'd4, 64'h0000000000000001, 6'd31, 64'hFFFFFFFF80000000);
    add_vec("srlw_4",    3'd5, 64'hFFFFFFFFFFFFFFFF, 6'd4,  64'h000000000FFFFFFF);
    add_vec("sraw_36",   3'd6, 64'h0000000080000000, 6'h24, 64'hFFFFFFFFF8000000);
    add_vec("sraw_0",    3'd6, 64'h1234567887654321, 6'd0,  64'hFFFFFFFF87654321);
    add_vec("sllw_0",    3'd4, 64'hFFFF00007FFFFFFF, 6'd0,  64'h000000007FFFFFFF);
    add_vec("rsvd_3",    3'd3, 64'hFFFFFFFFFFFFFFFF, 6'd1,  64'h0000000000000000);
    add_vec("rsvd_7",    3'd7, 64'hFFFFFFFFFFFFFFFF, 6'd1,  64'h0000000000000000);
    for (int s = 0; s < NI; s++) begin
      foreach (vq[v]) begin
        in_op = vq[v].op; in_a = vq[v].a; in_shamt = vq[v].sh; in_tag = 5'(v + 3);
        in_valid_v[s] = 1'b1; out_ready_v[s] = 1'b1;
        #1;
        n = 0;
        while (in_ready_v[s] !== 1'b1 && n < 20) begin cycle(); n++; end
        checks++;
        if (in_ready_v[s] !== 1'b1) begin
          errors++; $display("FAIL %s_accept[%0d]: in_ready got %b expected 1", vq[v].name, s, in_ready_v[s]);
        end
        cycle();
        in_valid_v[s] = 1'b0;
        lat = 0;
        while (out_valid_v[s] !== 1'b1 && lat < 20) begin cycle(); lat++; end
        checks++;
        if (lat != ps_of(s) - 1) begin
          errors++; $display("FAIL %s_latency[%0d]: got %0d expected %0d", vq[v].name, s, lat, ps_of(s) - 1);
        end
        checks++;
        if (out_y_v[s] !== vq[v].y) begin
          errors++; $display("FAIL %s_y[%0d]: got %h expected %h", vq[v].name, s, out_y_v[s], vq[v].y);
        end
        checks++;
        if (out_tag_v[s] !== 5'(v + 3)) begin
          errors++; $display("FAIL %s_tag[%0d]: got %h expected %h", vq[v].name, s, out_tag_v[s], 5'(v + 3));
        end
        cycle();
      end
      idle_inputs();
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [8];
    logic [63:0] as  [8];
    logic [5:0]  shs [8];
    int          ps;
    logic        exp_v;
    logic [63:0] exp_y;
    for (int s = 0; s < NI; s++) begin
      ps = ps_of(s);
      out_ready_v[s] = 1'b1;
      for (int t = 0; t < 8 + ps + 2; t++) begin
        if (t < 8) begin
          ops[t] = 3'($urandom_range(0, 7));
          as[t]  = {$urandom, $urandom};
          shs[t] = 6'($urandom_range(0, 63));
          in_op = ops[t]; in_a = as[t]; in_shamt = shs[t]; in_tag = 5'(t + 8 * s);
          in_valid_v[s] = 1'b1;
        end else begin
          in_valid_v[s] = 1'b0;
        end
        #1;
        if (t < 8) begin
          checks++;
          if (in_ready_v[s] !== 1'b1) begin
            errors++; $display("FAIL b2b_in_ready[%0d] t=%0d: got %b expected 1", s, t, in_ready_v[s]);
          end
        end
        exp_v = (t >= ps) && (t < ps + 8);
        checks++;
        if (out_valid_v[s] !== exp_v) begin
          errors++; $display("FAIL b2b_out_valid[%0d] t=%0d: got %b expected %b", s, t, out_valid_v[s], exp_v);
        end
        if (exp_v) begin
          exp_y = ref_shift(ops[t-ps], as[t-ps], shs[t-ps]);
          checks++;
          if (out_y_v[s] !== exp_y) begin
            errors++; $display("FAIL b2b_y[%0d] t=%0d: got %h expected %h", s, t, out_y_v[s], exp_y);
          end
          checks++;
          if (out_tag_v[s] !== 5'(t - ps + 8 * s)) begin
            errors++; $display("FAIL b2b_tag[%0d] t=%0d: got %h expected %h", s, t, out_tag_v[s], 5'(t - ps + 8 * s));
          end
        end
        cycle();
      end
      idle_inputs();
    end
  endtask

  task automatic test_backpressure();
    logic [2:0]  ops [4];
    logic [63:0] as  [4];
    logic [5:0]  shs [4];
    int          idx;
    int          got;
    int          n;
    int          cap;
    exp_t        e;
    for (int s = 0; s < NI; s++) begin
      exp_q.delete();
      cap = (ps_of(s) < 4) ? ps_of(s) : 4;
      for (int i = 0; i < 4; i++) begin
        ops[i] = 3'($urandom_range(0, 6));
        as[i]  = {$urandom, $urandom};
        shs[i] = 6'($urandom_range(0, 63));
      end
      idx = 0; got = 0;
      out_ready_v[s] = 1'b0;
      for (int t = 0; t < 8 + ps_of(s); t++) begin
        in_valid_v[s] = (idx < 4);
        if (idx < 4) begin
          in_op = ops[idx]; in_a = as[idx]; in_shamt = shs[idx]; in_tag = 5'(20 + idx);
        end
        #1;
        if (out_valid_v[s] === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL bp_hold_spurious[%0d]: out_valid got 1 expected 0", s);
          end else if (out_y_v[s] !== exp_q[0].y || out_tag_v[s] !== exp_q[0].tag) begin
            errors++; $display("FAIL bp_hold[%0d]: got %h/%h expected %h/%h", s, out_y_v[s], out_tag_v[s], exp_q[0].y, exp_q[0].tag);
          end
        end
        if (in_valid_v[s] && in_ready_v[s]) begin
          e.y = ref_shift(ops[idx], as[idx], shs[idx]); e.tag = 5'(20 + idx);
          exp_q.push_back(e);
          idx++;
        end
        cycle();
      end
      checks++;
      if (idx != cap) begin
        errors++; $display("FAIL bp_accepted[%0d]: got %0d expected %0d", s, idx, cap);
      end
      checks++;
      if (in_ready_v[s] !== (ps_of(s) > 4)) begin
        errors++; $display("FAIL bp_in_ready[%0d]: got %b expected %b", s, in_ready_v[s], ps_of(s) > 4);
      end
      out_ready_v[s] = 1'b1;
      n = 0;
      while ((idx < 4 || exp_q.size() > 0) && n < 40) begin
        in_valid_v[s] = (idx < 4);
        if (idx < 4) begin
          in_op = ops[idx]; in_a = as[idx]; in_shamt = shs[idx]; in_tag = 5'(20 + idx);
        end
        #1;
        if (out_valid_v[s] === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL bp_drain_spurious[%0d]: out_tag got %h expected none", s, out_tag_v[s]);
          end else begin
            if (out_y_v[s] !== exp_q[0].y || out_tag_v[s] !== exp_q[0].tag) begin
              errors++; $display("FAIL bp_drain[%0d]: got %h/%h expected %h/%h", s, out_y_v[s], out_tag_v[s], exp_q[0].y, exp_q[0].tag);
            end
            void'(exp_q.pop_front());
            got++;
          end
        end
        if (in_valid_v[s] && in_ready_v[s]) begin
          e.y = ref_shift(ops[idx], as[idx], shs[idx]); e.tag = 5'(20 + idx);
          exp_q.push_back(e);
          idx++;
        end
        cycle();
        n++;
      end
      checks++;
      if (got != 4) begin
        errors++; $display("FAIL bp_results[%0d]: got %0d expected 4", s, got);
      end
      idle_inputs();
    end
  endtask

  task automatic test_random();
    exp_t e;
    int   n;
    for (int s = 0; s < NI; s++) begin
      exp_q.delete();
      for (int t = 0; t < 330; t++) begin
        if (t < 300) begin
          in_valid_v[s]  = ($urandom_range(0, 3) != 0);
          out_ready_v[s] = ($urandom_range(0, 2) != 0);
        end else begin
          in_valid_v[s]  = 1'b0;
          out_ready_v[s] = 1'b1;
        end
        in_op = 3'($urandom_range(0, 7)); in_a = {$urandom, $urandom};
        in_shamt = 6'($urandom_range(0, 63)); in_tag = 5'($urandom_range(0, 31));
        #1;
        if (out_valid_v[s] === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL rnd_spurious[%0d] t=%0d: out_tag got %h expected none", s, t, out_tag_v[s]);
          end else begin
            if (out_y_v[s] !== exp_q[0].y || out_tag_v[s] !== exp_q[0].tag) begin
              errors++; $display("FAIL rnd_result[%0d] t=%0d: got %h/%h expected %h/%h", s, t, out_y_v[s], out_tag_v[s], exp_q[0].y, exp_q[0].tag);
            end
            if (out_ready_v[s]) void'(exp_q.pop_front());
          end
        end
        if (in_valid_v[s] && in_ready_v[s]) begin
          e.y = ref_shift(in_op, in_a, in_shamt); e.tag = in_tag;
          exp_q.push_back(e);
        end
        cycle();
      end
      n = exp_q.size();
      checks++;
      if (n != 0) begin
        errors++; $display("FAIL rnd_lost[%0d]: got %0d outstanding expected 0", s, n);
      end
      idle_inputs();
    end
  endtask

  task automatic test_reset_flush();
    int n;
    int lat;
    int want;
    for (int s = 0; s < NI; s++) begin
      want = (ps_of(s) < 2) ? ps_of(s) : 2;
      out_ready_v[s] = 1'b0;
      n = 0;
      for (int t = 0; t < 6 && n < want; t++) begin
        in_op = 3'd0; in_a = {$urandom, $urandom}; in_shamt = 6'd1; in_tag = 5'(t + 1);
        in_valid_v[s] = 1'b1;
        #1;
        if (in_ready_v[s]) n++;
        cycle();
      end
      in_valid_v[s] = 1'b0;
      checks++;
      if (n != want) begin
        errors++; $display("FAIL flush_fill[%0d]: got %0d expected %0d", s, n, want);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready_v[s] !== 1'b0) begin
        errors++; $display("FAIL flush_in_ready[%0d]: got %b expected 0", s, in_ready_v[s]);
      end
      cycle();
      checks++;
      if (out_valid_v[s] !== 1'b0 || out_y_v[s] !== 64'd0 || out_tag_v[s] !== 5'd0) begin
        errors++; $display("FAIL flush_clear[%0d]: got %b/%h/%h expected 0/0/0", s, out_valid_v[s], out_y_v[s], out_tag_v[s]);
      end
      rst_n = 1'b1;
      out_ready_v[s] = 1'b1;
      for (int t = 0; t < 8; t++) begin
        #1;
        checks++;
        if (out_valid_v[s] !== 1'b0) begin
          errors++; $display("FAIL flush_ghost[%0d] t=%0d: out_valid got %b expected 0", s, t, out_valid_v[s]);
        end
        cycle();
      end
      in_op = 3'd2; in_a = 64'hF000000000000000; in_shamt = 6'd4; in_tag = 5'h1F;
      in_valid_v[s] = 1'b1;
      #1;
      checks++;
      if (in_ready_v[s] !== 1'b1) begin
        errors++; $display("FAIL flush_next_accept[%0d]: got %b expected 1", s, in_ready_v[s]);
      end
      cycle();
      in_valid_v[s] = 1'b0;
      lat = 0;
      while (out_valid_v[s] !== 1'b1 && lat < 20) begin cycle(); lat++; end
      checks++;
      if (out_valid_v[s] !== 1'b1 || out_y_v[s] !== 64'hFF00000000000000 || out_tag_v[s] !== 5'h1F) begin
        errors++; $display("FAIL flush_next_result[%0d]: got %b/%h/%h expected 1/ff00000000000000/1f", s, out_valid_v[s], out_y_v[s], out_tag_v[s]);
      end
      cycle();
      idle_inputs();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
